// File: rtl/datapath_sequencer_pkg.sv
// Shared encodings for the multicycle control sequencer and its datapath:
// state codes, instruction fields, ALU operations and mux selects.
package datapath_sequencer_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        FETCH    = 4'd1,
        FWAIT    = 4'd2,
        DECODE   = 4'd3,
        R_EXE    = 4'd4,
        R_WB     = 4'd5,
        I_EXE    = 4'd6,
        I_WB     = 4'd7,
        MEM_ADDR = 4'd8,
        LW_RD    = 4'd9,
        LW_WAIT  = 4'd10,
        LW_WB    = 4'd11,
        SW_WR    = 4'd12,
        BRANCH   = 4'd13,
        JUMP     = 4'd14,
        EXC      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;

    localparam logic [2:0] IORD_PC      = 3'd0;
    localparam logic [2:0] IORD_ALU_OUT = 3'd1;

    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_A  = 2'd1;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_IMM     = 2'd1;
    localparam logic [1:0] SRCB_FOUR    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [2:0] DST_RT = 3'd0;
    localparam logic [2:0] DST_RD = 3'd1;

    localparam logic [2:0] WB_ALU_OUT = 3'd0;
    localparam logic [2:0] WB_MEM     = 3'd1;

    localparam logic [2:0] PCSRC_NONE       = 3'd0;
    localparam logic [2:0] PCSRC_ALU_RESULT = 3'd1;
    localparam logic [2:0] PCSRC_ALU_OUT    = 3'd2;
    localparam logic [2:0] PCSRC_JUMP       = 3'd4;

    typedef struct packed {
        logic       pc_w;
        logic       mem_rw;
        logic       ir_w;
        logic       reg_w;
        logic       ab_w;
        logic       alu_out_w;
        logic [2:0] alu_c;
        logic [2:0] iord_sel;
        logic [1:0] src_a_sel;
        logic [1:0] src_b_sel;
        logic [2:0] reg_dst_sel;
        logic [2:0] mem_to_reg_sel;
        logic [2:0] pc_source_sel;
        logic       reset_out;
        logic       exc;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic is_r_funct(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] f);
        logic [2:0] op;
        op = ALU_ADD;
        if (f == FN_SUB) op = ALU_SUB;
        if (f == FN_AND) op = ALU_AND;
        return op;
    endfunction

endpackage

// File: rtl/datapath_sequencer.sv
// Multicycle control FSM: Moore outputs decoded from state, except branch
// PC_w (from zero) and the overflow-driven jump to the exception state.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       PC_w,
    output logic       MEM_rw,
    output logic       IR_w,
    output logic       REG_w,
    output logic       AB_w,
    output logic       ALU_OUT_w,
    output logic [2:0] ALU_c,
    output logic [2:0] Iord_sel,
    output logic [1:0] ALUSrcA_sel,
    output logic [1:0] ALUSrcB_sel,
    output logic [2:0] Reg_dst_sel,
    output logic [2:0] Mem_to_reg_sel,
    output logic [2:0] PC_source_sel,
    output logic       reset_out,
    output logic       exc
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // Async clear lands in S_RST, whose decode has no write enables,
    // so an in-flight memory or register write is dropped at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_IDLE;
        case (state_q)
            S_RST: begin
                ctrl.reset_out = 1'b1;
                state_d        = FETCH;
            end
            FETCH: begin
                ctrl.iord_sel = IORD_PC;
                state_d       = FWAIT;
            end
            FWAIT: begin
                ctrl.ir_w          = 1'b1;
                ctrl.pc_w          = 1'b1;
                ctrl.src_a_sel     = SRCA_PC;
                ctrl.src_b_sel     = SRCB_FOUR;
                ctrl.alu_c         = ALU_ADD;
                ctrl.pc_source_sel = PCSRC_ALU_RESULT;
                state_d            = DECODE;
            end
            DECODE: begin
                ctrl.ab_w      = 1'b1;
                ctrl.alu_out_w = 1'b1;
                ctrl.src_a_sel = SRCA_PC;
                ctrl.src_b_sel = SRCB_IMM_SH2;
                ctrl.alu_c     = ALU_ADD;
                state_d        = EXC;
                if (opcode == OP_RTYPE && is_r_funct(funct))
                    state_d = R_EXE;
                else if (opcode == OP_ADDI)
                    state_d = I_EXE;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_d = MEM_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_d = BRANCH;
                else if (opcode == OP_J)
                    state_d = JUMP;
            end
            R_EXE: begin
                ctrl.src_a_sel = SRCA_A;
                ctrl.src_b_sel = SRCB_B;
                ctrl.alu_out_w = 1'b1;
                ctrl.alu_c     = r_alu_op(funct);
                if (overflow && funct != FN_AND) state_d = EXC;
                else                             state_d = R_WB;
            end
            R_WB: begin
                ctrl.reg_w          = 1'b1;
                ctrl.reg_dst_sel    = DST_RD;
                ctrl.mem_to_reg_sel = WB_ALU_OUT;
                state_d             = FETCH;
            end
            I_EXE: begin
                ctrl.src_a_sel = SRCA_A;
                ctrl.src_b_sel = SRCB_IMM;
                ctrl.alu_c     = ALU_ADD;
                ctrl.alu_out_w = 1'b1;
                state_d        = overflow ? EXC : I_WB;
            end
            I_WB: begin
                ctrl.reg_w          = 1'b1;
                ctrl.reg_dst_sel    = DST_RT;
                ctrl.mem_to_reg_sel = WB_ALU_OUT;
                state_d             = FETCH;
            end
            MEM_ADDR: begin
                ctrl.src_a_sel = SRCA_A;
                ctrl.src_b_sel = SRCB_IMM;
                ctrl.alu_c     = ALU_ADD;
                ctrl.alu_out_w = 1'b1;
                state_d        = (opcode == OP_LW) ? LW_RD : SW_WR;
            end
            LW_RD: begin
                ctrl.iord_sel = IORD_ALU_OUT;
                state_d       = LW_WAIT;
            end
            LW_WAIT: begin
                ctrl.iord_sel = IORD_ALU_OUT;
                state_d       = LW_WB;
            end
            LW_WB: begin
                ctrl.reg_w          = 1'b1;
                ctrl.reg_dst_sel    = DST_RT;
                ctrl.mem_to_reg_sel = WB_MEM;
                state_d             = FETCH;
            end
            SW_WR: begin
                ctrl.iord_sel = IORD_ALU_OUT;
                ctrl.mem_rw   = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                ctrl.src_a_sel     = SRCA_A;
                ctrl.src_b_sel     = SRCB_B;
                ctrl.alu_c         = ALU_SUB;
                ctrl.pc_source_sel = PCSRC_ALU_OUT;
                ctrl.pc_w = (opcode == OP_BEQ) ? zero : ~zero;
                state_d            = FETCH;
            end
            JUMP: begin
                ctrl.pc_source_sel = PCSRC_JUMP;
                ctrl.pc_w          = 1'b1;
                state_d            = FETCH;
            end
            EXC: begin
                ctrl.exc = 1'b1;
                state_d  = FETCH;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    assign PC_w           = ctrl.pc_w;
    assign MEM_rw         = ctrl.mem_rw;
    assign IR_w           = ctrl.ir_w;
    assign REG_w          = ctrl.reg_w;
    assign AB_w           = ctrl.ab_w;
    assign ALU_OUT_w      = ctrl.alu_out_w;
    assign ALU_c          = ctrl.alu_c;
    assign Iord_sel       = ctrl.iord_sel;
    assign ALUSrcA_sel    = ctrl.src_a_sel;
    assign ALUSrcB_sel    = ctrl.src_b_sel;
    assign Reg_dst_sel    = ctrl.reg_dst_sel;
    assign Mem_to_reg_sel = ctrl.mem_to_reg_sel;
    assign PC_source_sel  = ctrl.pc_source_sel;
    assign reset_out      = ctrl.reset_out;
    assign exc            = ctrl.exc;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed per-cycle vector table for the control sequencer, plus an
// asynchronous reset dropped into the middle of a load.
module tb_datapath_sequencer;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       zero;
    logic       PC_w, MEM_rw, IR_w, REG_w, AB_w, ALU_OUT_w;
    logic [2:0] ALU_c, Iord_sel, Reg_dst_sel, Mem_to_reg_sel, PC_source_sel;
    logic [1:0] ALUSrcA_sel, ALUSrcB_sel;
    logic       reset_out, exc;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero),
        .PC_w(PC_w), .MEM_rw(MEM_rw), .IR_w(IR_w), .REG_w(REG_w),
        .AB_w(AB_w), .ALU_OUT_w(ALU_OUT_w), .ALU_c(ALU_c),
        .Iord_sel(Iord_sel), .ALUSrcA_sel(ALUSrcA_sel),
        .ALUSrcB_sel(ALUSrcB_sel), .Reg_dst_sel(Reg_dst_sel),
        .Mem_to_reg_sel(Mem_to_reg_sel), .PC_source_sel(PC_source_sel),
        .reset_out(reset_out), .exc(exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {PC_w, MEM_rw, IR_w, REG_w, AB_w, ALU_OUT_w}
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       ov;
        logic       z;
        logic [3:0] st;
        logic [5:0] en;
        logic [2:0] alu;
        logic [2:0] iord;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] rd;
        logic [2:0] m2r;
        logic [2:0] pcs;
        logic       ro;
        logic       ex;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(
        input logic [5:0] op, input logic [5:0] fn,
        input logic ov, input logic z, input logic [3:0] st,
        input logic [5:0] en, input logic [2:0] alu,
        input logic [2:0] iord, input logic [1:0] a,
        input logic [1:0] b, input logic [2:0] rd,
        input logic [2:0] m2r, input logic [2:0] pcs,
        input logic ro, input logic ex);
        vec_t r;
        r.op = op; r.fn = fn; r.ov = ov; r.z = z; r.st = st;
        r.en = en; r.alu = alu; r.iord = iord; r.a = a; r.b = b;
        r.rd = rd; r.m2r = m2r; r.pcs = pcs; r.ro = ro; r.ex = ex;
        return r;
    endfunction

    // FETCH, FWAIT, DECODE rows shared by every instruction
    task automatic add_common(input logic [5:0] op, input logic [5:0] fn);
        tbl.push_back(v(op, fn, 0, 0, 4'd1, 6'b000000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(op, fn, 0, 0, 4'd2, 6'b101000, 3'd1, 3'd0, 2'd0, 2'd2, 3'd0, 3'd0, 3'd1, 0, 0));
        tbl.push_back(v(op, fn, 0, 0, 4'd3, 6'b000011, 3'd1, 3'd0, 2'd0, 2'd3, 3'd0, 3'd0, 3'd0, 0, 0));
    endtask

    function automatic logic [26:0] obs_vec();
        return {PC_w, MEM_rw, IR_w, REG_w, AB_w, ALU_OUT_w, ALU_c, Iord_sel,
                ALUSrcA_sel, ALUSrcB_sel, Reg_dst_sel, Mem_to_reg_sel,
                PC_source_sel, reset_out, exc};
    endfunction

    function automatic logic [26:0] exp_vec(input vec_t r);
        return {r.en, r.alu, r.iord, r.a, r.b, r.rd, r.m2r, r.pcs, r.ro, r.ex};
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, expv);
        end
    endtask

    // Entered just after a falling edge; leaves at the next falling edge.
    task automatic run_row(input vec_t r, input int idx);
        opcode   = r.op;
        funct    = r.fn;
        overflow = r.ov;
        zero     = r.z;
        #1;
        chk("state", idx, 32'(dut.state_q), 32'(r.st));
        chk("outputs", idx, 32'(obs_vec()), 32'(exp_vec(r)));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct = '0; overflow = 1'b0; zero = 1'b0;

        // S_RST row follows the release
        tbl.push_back(v(0, 0, 0, 0, 4'd0, 6'b000000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1, 0));
        // add $8,$9,$10
        add_common(6'h00, 6'h20);
        tbl.push_back(v(6'h00, 6'h20, 0, 0, 4'd4, 6'b000001, 3'd1, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h00, 6'h20, 0, 0, 4'd5, 6'b000100, 3'd0, 3'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 0, 0));
        // lw, overflow in MEM_ADDR is ignored
        add_common(6'h23, 6'h04);
        tbl.push_back(v(6'h23, 6'h04, 1, 0, 4'd8, 6'b000001, 3'd1, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h23, 6'h04, 0, 0, 4'd9, 6'b000000, 3'd0, 3'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h23, 6'h04, 0, 0, 4'd10, 6'b000000, 3'd0, 3'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h23, 6'h04, 0, 0, 4'd11, 6'b000100, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd1, 3'd0, 0, 0));
        // sw
        add_common(6'h2B, 6'h04);
        tbl.push_back(v(6'h2B, 6'h04, 0, 0, 4'd8, 6'b000001, 3'd1, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h2B, 6'h04, 0, 0, 4'd12, 6'b010000, 3'd0, 3'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        // beq taken
        add_common(6'h04, 6'h00);
        tbl.push_back(v(6'h04, 6'h00, 0, 1, 4'd13, 6'b100000, 3'd2, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0));
        // bne with zero=1, not taken
        add_common(6'h05, 6'h00);
        tbl.push_back(v(6'h05, 6'h00, 0, 1, 4'd13, 6'b000000, 3'd2, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0));
        // bne taken
        add_common(6'h05, 6'h00);
        tbl.push_back(v(6'h05, 6'h00, 0, 0, 4'd13, 6'b100000, 3'd2, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0));
        // beq not taken
        add_common(6'h04, 6'h00);
        tbl.push_back(v(6'h04, 6'h00, 0, 0, 4'd13, 6'b000000, 3'd2, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd2, 0, 0));
        // addi with overflow -> EXC
        add_common(6'h08, 6'h10);
        tbl.push_back(v(6'h08, 6'h10, 1, 0, 4'd6, 6'b000001, 3'd1, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h08, 6'h10, 0, 0, 4'd15, 6'b000000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 1));
        // addi clean
        add_common(6'h08, 6'h10);
        tbl.push_back(v(6'h08, 6'h10, 0, 0, 4'd6, 6'b000001, 3'd1, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h08, 6'h10, 0, 0, 4'd7, 6'b000100, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        // sub with overflow -> EXC
        add_common(6'h00, 6'h22);
        tbl.push_back(v(6'h00, 6'h22, 1, 0, 4'd4, 6'b000001, 3'd2, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h00, 6'h22, 0, 0, 4'd15, 6'b000000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 1));
        // and ignores overflow
        add_common(6'h00, 6'h24);
        tbl.push_back(v(6'h00, 6'h24, 1, 0, 4'd4, 6'b000001, 3'd3, 3'd0, 2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h00, 6'h24, 0, 0, 4'd5, 6'b000100, 3'd0, 3'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 0, 0));
        // j
        add_common(6'h02, 6'h00);
        tbl.push_back(v(6'h02, 6'h00, 0, 0, 4'd14, 6'b100000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd4, 0, 0));
        // illegal opcode 0x3F
        add_common(6'h3F, 6'h00);
        tbl.push_back(v(6'h3F, 6'h00, 0, 0, 4'd15, 6'b000000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 1));
        // R-type with unsupported funct 0x21
        add_common(6'h00, 6'h21);
        tbl.push_back(v(6'h00, 6'h21, 0, 0, 4'd15, 6'b000000, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 1));
        // lw up to LW_RD; reset is dropped in LW_WAIT below
        add_common(6'h23, 6'h04);
        tbl.push_back(v(6'h23, 6'h04, 0, 0, 4'd8, 6'b000001, 3'd1, 3'd0, 2'd1, 2'd1, 3'd0, 3'd0, 3'd0, 0, 0));
        tbl.push_back(v(6'h23, 6'h04, 0, 0, 4'd9, 6'b000000, 3'd0, 3'd1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0));

        // Held in reset across two rising edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 0, 32'(dut.state_q), 32'd0);
        chk("rst_outputs", 0, 32'(obs_vec()), 32'h2);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            run_row(tbl[i], i);

        // Now in LW_WAIT: drop reset between edges
        #1;
        chk("lw_wait_state", 0, 32'(dut.state_q), 32'd10);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_state", 0, 32'(dut.state_q), 32'd0);
        chk("async_rst_outputs", 0, 32'(obs_vec()), 32'h2);
        @(posedge clk);
        #1;
        chk("held_rst_state", 0, 32'(dut.state_q), 32'd0);
        chk("held_rst_reg_w", 0, 32'(REG_w), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_state", 0, 32'(dut.state_q), 32'd0);
        chk("release_reset_out", 0, 32'(reset_out), 32'd1);
        @(negedge clk);
        #1;
        chk("first_fetch", 0, 32'(dut.state_q), 32'd1);
        chk("first_fetch_outputs", 0, 32'(obs_vec()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- overflow  in  1  ALU overflow, combinational.
- zero  in  1  ALU zero flag, combinational.
REQ-002 SHALL have ports:
- PC_w, MEM_rw, IR_w, REG_w, AB_w, ALU_OUT_w  out  1 each  write enables; MEM_rw=1 means write.
- ALU_c  out  3  ALU op: 000 load A, 001 add, 010 sub, 011 and.
- Iord_sel  out  3  memory address: 0 PC, 1 ALU_out.
- ALUSrcA_sel  out  2  0 PC, 1 A.
- ALUSrcB_sel  out  2  0 B, 1 sign-extended imm, 2 constant 4, 3 sign-extended imm<<2.
- Reg_dst_sel  out  3  0 rt, 1 rd.
- Mem_to_reg_sel  out  3  0 ALU_out, 1 memory data.
- PC_source_sel  out  3  1 ALU_result, 2 ALU_out, 4 jump target.
- reset_out  out  1  datapath register clear.
- exc  out  1  exception pulse.

Function
REQ-003 SHALL be a Moore FSM with a 4-bit state register; every output is decoded from state only, except branch PC_w and the EXC transition.
REQ-004 SHALL drive, in every state, all enables at 0, all selects at 0, ALU_c 000 and exc 0 unless a REQ below states otherwise.
REQ-005 SHALL use states S_RST=0, FETCH=1, FWAIT=2, DECODE=3, R_EXE=4, R_WB=5, I_EXE=6, I_WB=7, MEM_ADDR=8, LW_RD=9, LW_WAIT=10, LW_WB=11, SW_WR=12, BRANCH=13, JUMP=14, EXC=15.
REQ-006 S_RST SHALL drive reset_out=1 and go to FETCH.
REQ-007 FETCH SHALL drive Iord=0 and MEM_rw=0, then go to FWAIT.
REQ-008 FWAIT SHALL drive:
- IR_w=1, PC_w=1.
- ALUSrcA=0, ALUSrcB=2, ALU_c=001, PC_source=1 (PC<=PC+4).
- next state DECODE.
REQ-009 DECODE SHALL drive AB_w=1, ALU_OUT_w=1, ALUSrcA=0, ALUSrcB=3, ALU_c=001 (branch target into ALU_out), then dispatch on opcode:
- 0x00 with funct 0x20/0x22/0x24 -> R_EXE.
- 0x08 -> I_EXE.
- 0x23 or 0x2B -> MEM_ADDR.
- 0x04 or 0x05 -> BRANCH.
- 0x02 -> JUMP.
- any other opcode or funct -> EXC.
REQ-010 R_EXE SHALL drive ALUSrcA=1, ALUSrcB=0, ALU_OUT_w=1, and ALU_c 001/010/011 for funct 0x20/0x22/0x24; next state is EXC if overflow=1 and funct is not 0x24, else R_WB.
REQ-011 R_WB SHALL drive REG_w=1, Reg_dst=1, Mem_to_reg=0, then go to FETCH.
REQ-012 I_EXE SHALL drive ALUSrcA=1, ALUSrcB=1, ALU_c=001, ALU_OUT_w=1; next state is EXC on overflow, else I_WB.
REQ-013 I_WB SHALL drive REG_w=1, Reg_dst=0, Mem_to_reg=0, then go to FETCH.
REQ-014 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=1, ALU_c=001, ALU_OUT_w=1 (overflow ignored); next state is LW_RD for 0x23, SW_WR for 0x2B.
REQ-015 LW_RD SHALL drive Iord=1 -> LW_WAIT; LW_WAIT SHALL drive Iord=1 -> LW_WB; LW_WB SHALL drive REG_w=1, Reg_dst=0, Mem_to_reg=1 -> FETCH.
REQ-016 SW_WR SHALL drive Iord=1, MEM_rw=1 for exactly one cycle, then go to FETCH.
REQ-017 BRANCH SHALL drive:
- ALUSrcA=1, ALUSrcB=0, ALU_c=010, PC_source=2.
- PC_w = zero for 0x04, ~zero for 0x05.
- next state FETCH.
REQ-018 JUMP SHALL drive PC_source=4, PC_w=1, then go to FETCH.
REQ-019 EXC SHALL drive exc=1 for one cycle with no write enable active (the faulting result is discarded and PC keeps PC+4), then go to FETCH.
REQ-020 opcode and funct SHALL be read only in DECODE and in the EXE/MEM_ADDR states that follow it; the IR is stable there.

Reset
REQ-021 reset=0 SHALL force state S_RST immediately, regardless of clk.
REQ-022 While reset=0 (including mid-instruction), outputs SHALL be all 0 except reset_out=1; no pending memory write or register write may complete.
REQ-023 After reset rises, the first clk edge SHALL leave S_RST, so the first FETCH is the second cycle.

Structure
REQ-024 State encodings, opcode/funct constants, ALU_c codes and mux-select codes SHALL live in a shared package used by both this block and the datapath.
REQ-025 Output decode SHALL be one combinational block; no sub-module is needed.

Verification
REQ-026 Reset released -> reset_out=1 for one cycle; FETCH on the next cycle; add 0x012A4020 -> states 1,2,3,4,5, and REG_w=1 with Reg_dst=1 in the 5th cycle.
REQ-027 lw 0x8D090004 -> states 1,2,3,8,9,10,11; Mem_to_reg=1 and REG_w=1 only in state 11; sw 0xAD09... -> MEM_rw=1 for exactly one cycle.
REQ-028 beq with zero=1 -> PC_w=1 and PC_source=2 in BRANCH; bne with zero=1 -> PC_w=0.
REQ-029 addi with overflow=1 in I_EXE -> EXC, exc=1 for one cycle, REG_w never asserted, next state FETCH.
REQ-030 opcode 0x3F -> EXC directly from DECODE; reset=0 asserted in LW_WAIT -> S_RST asynchronously, REG_w stays 0.
